// File: rtl/vc_rr_arbiter.sv
// vc_rr_arbiter: shares one registered destination stage between 4 VC FIFOs, one word per cycle.
// Round-robin by default; define VC_ARB_STRICT_PRIO_EN for fixed priority (VC0 highest).
module vc_rr_arbiter #(
  parameter int BITNUMBER   = 6,
  parameter int STALL_LIMIT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             src_can_pop,
  input  logic [4*BITNUMBER-1:0] src_data,
  input  logic [3:0]             dst_pause,
  output logic [3:0]             src_pop,
  output logic [3:0]             dst_push,
  output logic [BITNUMBER-1:0]   dst_data,
  output logic [1:0]             grant_vc,
  output logic [1:0]             state,
  output logic                   stall_err
);
  typedef enum logic [1:0] {IDLE = 2'b00, ARB = 2'b01, STALL = 2'b10} state_t;
  state_t state_q, state_d;
  logic [BITNUMBER-1:0] word [4];
  logic [1:0] dest [4];
  logic [3:0] elig;
  logic grant;
  logic [1:0] win;
  logic [3:0] dst_push_q, dst_push_d;
  logic [BITNUMBER-1:0] dst_data_q, dst_data_d;
  logic [1:0] grant_vc_q, grant_vc_d;
  logic [3:0] cnt_q, cnt_d;
  logic stall_err_q, stall_err_d;
  genvar v;
  generate
    for (v = 0; v < 4; v++) begin : g_vc
      assign word[v] = src_data[v*BITNUMBER +: BITNUMBER];
      assign dest[v] = word[v][BITNUMBER-1 -: 2];
      assign elig[v] = src_can_pop[v] & ~dst_pause[dest[v]];
    end
  endgenerate
  assign grant = |elig;
`ifdef VC_ARB_STRICT_PRIO_EN
  always_comb begin
    win = elig[0] ? 2'd0 : elig[1] ? 2'd1 : elig[2] ? 2'd2 : 2'd3;
  end
`else
  logic [1:0] ptr_q, ptr_d;
  // Scan from the far end back to the pointer so the closest eligible VC wins.
  always_comb begin
    win = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (elig[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
    end
    ptr_d = grant ? win + 2'd1 : ptr_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 2'd0;
    else ptr_q <= ptr_d;
  end
`endif
  always_comb begin
    dst_push_d  = grant ? 4'b0001 << dest[win] : 4'b0000;
    dst_data_d  = grant ? word[win] : dst_data_q;
    grant_vc_d  = grant ? win : grant_vc_q;
    state_d     = ~|src_can_pop ? IDLE : grant ? ARB : STALL;
    cnt_d       = (state_q == STALL && state_d == STALL) ?
                  (cnt_q == 4'(STALL_LIMIT) ? cnt_q : cnt_q + 4'd1) : 4'd0;
    stall_err_d = cnt_d == 4'(STALL_LIMIT);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dst_push_q  <= '0;
      dst_data_q  <= '0;
      grant_vc_q  <= '0;
      cnt_q       <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dst_push_q  <= dst_push_d;
      dst_data_q  <= dst_data_d;
      grant_vc_q  <= grant_vc_d;
      cnt_q       <= cnt_d;
      stall_err_q <= stall_err_d;
    end
  end
  // The pop strobe is combinational, so reset must mask it directly.
  assign src_pop   = (grant && !reset) ? 4'b0001 << win : 4'b0000;
  assign dst_push  = dst_push_q;
  assign dst_data  = dst_data_q;
  assign grant_vc  = grant_vc_q;
  assign state     = state_q;
  assign stall_err = stall_err_q;
endmodule

// File: doc/vc_rr_arbiter.md
Name: vc_rr_arbiter

Overview:
- Shares one output path between 4 source FIFOs (virtual channels).
- Each cycle it selects at most one non-empty source whose head word targets a destination that is not paused, pops that word and registers it into the destination stage.
- Sits between the VC input FIFOs and the destination FIFOs.
- Consumes the can_pop/pause flags produced by the flow-control logic.

Parameters:
- BITNUMBER, 6, word width; bits [BITNUMBER-1:BITNUMBER-2] carry the destination index (0..3).
- STALL_LIMIT, 15, consecutive blocked cycles before stall_err asserts; counter width 4 bits.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- src_can_pop  in  4  per-VC "FIFO not empty" from flow control
- src_data  in  4*BITNUMBER  show-ahead head words; VCi occupies [i*BITNUMBER +: BITNUMBER]
- dst_pause  in  4  per-destination pause from flow control
- src_pop  out  4  one-hot pop strobe to the granted VC FIFO (combinational, same cycle as grant)
- dst_push  out  4  one-hot registered push to the destination FIFO
- dst_data  out  BITNUMBER  registered word accompanying dst_push
- grant_vc  out  2  registered index of the last granted VC
- state  out  2  FSM state: 00 IDLE, 01 ARB, 10 STALL
- stall_err  out  1  registered; set when blocked for STALL_LIMIT cycles

Behaviour:
- Reset (async, any time, including mid-transfer):
  - src_pop = 0 while reset is high.
  - dst_push = 0, dst_data = 0, grant_vc = 0.
  - RR pointer = 0, state = IDLE, stall counter = 0, stall_err = 0.
  - An in-flight word is dropped.
- Eligibility: VCi is eligible iff src_can_pop[i] = 1 and dst_pause[dest(src_data_i)] = 0.
- Round-robin arbitration:
  - Search starts at the pointer and proceeds pointer, pointer+1, ... mod 4.
  - The first eligible VC wins.
  - At the clock edge after a grant, pointer = winner+1 mod 4 (3 wraps to 0).
  - With no grant, the pointer holds.
- Grant cycle: src_pop[winner] = 1 in that cycle. At the next edge:
  - dst_data = src_data_winner
  - dst_push = one-hot(dest), grant_vc = winner
- Latency: 1 cycle from pop to push. Throughput: 1 word/cycle.
- If no grant, dst_push = 0 at the next edge; dst_data holds its previous value.
- dst_pause must assert with at least 1 free entry. One word already registered for a paused destination is still pushed; no new word is granted to that destination.
- Simultaneous requests from all 4 VCs with pointer = 2 are served in order 2, 3, 0, 1 over consecutive cycles.
- FSM, evaluated every cycle:
  - IDLE: src_can_pop = 0. Goes to ARB when any src_can_pop = 1 and some VC is eligible; goes to STALL when any src_can_pop = 1 and none is eligible.
  - ARB: a grant is issued. Goes to IDLE when all sources are empty, to STALL when sources are non-empty but none is eligible, otherwise stays in ARB.
  - STALL: no grant while data is pending. Goes to ARB as soon as any VC becomes eligible, to IDLE if all sources become empty.
- Stall counter:
  - Increments each cycle in STALL, saturating at STALL_LIMIT; clears on leaving STALL.
  - stall_err = 1 while counter = STALL_LIMIT; clears when the counter clears.
- Popping a VC whose src_can_pop = 0 is forbidden; the bench flags it as an error.

Optional Feature:
- Macro: VC_ARB_STRICT_PRIO_EN
- Defined: fixed priority, VC0 highest through VC3 lowest. The RR pointer is removed and grant_vc still reports the winner. All other behaviour is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Async reset asserted mid-stream (e.g. between two clock edges while a word is in flight) -> all outputs 0 immediately; the in-flight word is never pushed; pointer restarts at VC0 after release.
- All 4 VCs non-empty, all destinations open, pointer 0 -> grants 0,1,2,3,0 on consecutive cycles; each dst_push one cycle after its src_pop with matching data (e.g. VC2 head 6'b10_1010 -> dst_push = 4'b0100, dst_data = 6'b101010).
- VC0 and VC1 both target dest 3 and dst_pause[3] = 1, VC2 targets dest 0 -> only VC2 is granted; VC0/VC1 are never popped while the pause is held.
- Only VC1 non-empty, its destination paused for 20 cycles -> state = STALL; stall_err rises after 15 cycles in STALL; on pause release, ARB and VC1 is granted that cycle; stall_err clears.
- All sources drain to empty -> state returns to IDLE; src_pop = 0 and dst_push = 0 one cycle later.
- With VC_ARB_STRICT_PRIO_EN defined, VC0 and VC3 continuously non-empty -> VC0 is granted every cycle and VC3 only after VC0 empties.
